// File: rtl/fc_input_layer.sv
// Deserializer: pops LAYER_HEIGHT words from a show-ahead FIFO and presents them
// as one registered parallel vector on a valid/yumi handshake.
module fc_input_layer #(
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned LAYER_HEIGHT = 8
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [WORD_SIZE-1:0]                   data_i,
  input  logic                                   empty_i,
  output logic                                   ren_o,
  output logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_o,
  output logic                                   valid_o,
  input  logic                                   yumi_i
);

  localparam int unsigned CntW = $clog2(LAYER_HEIGHT);
  localparam logic [CntW-1:0] CntLast = CntW'(LAYER_HEIGHT - 1);

  typedef enum logic {StCollect, StFull} state_e;

  state_e                                state_q, state_d;
  logic [CntW-1:0]                       count_q, count_d;
  logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_q, data_d;
  logic                                  pop;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      StCollect: begin
        pop = ~empty_i;
        if (pop) begin
          data_d[count_q] = data_i;
          // Explicit wrap so non-power-of-two heights never run past the last element.
          if (count_q == CntLast) begin
            count_d = '0;
            state_d = StFull;
          end else begin
            count_d = count_q + CntW'(1);
          end
        end
      end
      StFull: begin
        if (yumi_i) begin
          // Overlap the consumer's take with the first pop of the next vector.
          pop     = ~empty_i;
          state_d = StCollect;
          if (pop) begin
            data_d[0] = data_i;
            count_d   = CntW'(1);
          end else begin
            count_d = '0;
          end
        end
      end
      default: state_d = StCollect;
    endcase
  end

  assign ren_o   = pop & ~reset_i;
  assign valid_o = (state_q == StFull);
  assign data_o  = data_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StCollect;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_fc_input_layer.sv
// Directed bench for fc_input_layer: a queue stands in for the show-ahead FIFO and
// each scenario checks timing, pop counts and the assembled vector.
module tb_fc_input_layer;

  localparam int unsigned WS = 16;
  localparam int unsigned LH = 8;

  logic                   clk;
  logic                   reset_i;
  logic [WS-1:0]          data_i;
  logic                   empty_i;
  logic                   ren_o;
  logic [LH-1:0][WS-1:0]  data_o;
  logic                   valid_o;
  logic                   yumi_i;

  fc_input_layer #(.WORD_SIZE(WS), .LAYER_HEIGHT(LH)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .data_i  (data_i),
    .empty_i (empty_i),
    .ren_o   (ren_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .yumi_i  (yumi_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WS-1:0]         fifo_q[$];
  int                    n_cmp = 0;
  int                    n_err = 0;
  int                    pops;
  int                    ren_cycles;
  logic                  last_ren;
  logic [LH-1:0][WS-1:0] exp_vec;
  logic [LH-1:0][WS-1:0] saved;
  int                    cyc;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, note whether a pop happens, then advance.
  task automatic tick(input logic yumi, input logic stall);
    empty_i = stall || (fifo_q.size() == 0);
    data_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    yumi_i  = yumi;
    #1;
    last_ren = ren_o;
    if (ren_o) begin
      pops++;
      ren_cycles++;
      void'(fifo_q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int maxc, input int st_at, input int st_len,
                            output int ncyc);
    logic stall;
    ncyc = 0;
    while (!valid_o && ncyc < maxc) begin
      stall = (ncyc >= st_at) && (ncyc < st_at + st_len);
      tick(1'b0, stall);
      if (stall) check_eq({tag, "_stall_ren"}, {127'b0, last_ren}, 128'd0);
      ncyc++;
    end
    check_eq({tag, "_valid_timeout"}, {127'b0, valid_o}, 128'd1);
  endtask

  task automatic push_seq(input logic [WS-1:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + WS'(i));
  endtask

  task automatic build_exp(input logic [WS-1:0] base);
    for (int i = 0; i < LH; i++) exp_vec[i] = base + WS'(i);
  endtask

  initial begin
    reset_i = 1'b1;
    empty_i = 1'b0;
    data_i  = 16'h1234;
    yumi_i  = 1'b0;
    pops = 0;
    ren_cycles = 0;
    last_ren = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_ren", {127'b0, ren_o}, 128'd0);
    check_eq("rst_valid", {127'b0, valid_o}, 128'd0);
    check_eq("rst_data", data_o, 128'd0);
    @(negedge clk);
    reset_i = 1'b0;

    // Back-to-back
    push_seq(16'd1, 8);
    pops = 0; ren_cycles = 0;
    wait_valid("b2b", 20, -1, 0, cyc);
    build_exp(16'd1);
    check_eq("b2b_latency", cyc, 8);
    check_eq("b2b_pops", pops, 8);
    check_eq("b2b_ren_cycles", ren_cycles, 8);
    check_eq("b2b_data", data_o, exp_vec);
    tick(1'b1, 1'b0);
    check_eq("b2b_take_ren", {127'b0, last_ren}, 128'd0);
    check_eq("b2b_valid_drop", {127'b0, valid_o}, 128'd0);

    // Stall for 3 cycles after word 4
    push_seq(16'd11, 8);
    pops = 0;
    wait_valid("stall", 30, 4, 3, cyc);
    build_exp(16'd11);
    check_eq("stall_latency", cyc, 11);
    check_eq("stall_pops", pops, 8);
    check_eq("stall_data", data_o, exp_vec);
    tick(1'b1, 1'b0);

    // Backpressure with non-empty FIFO, then zero-bubble restart
    push_seq(16'd21, 8);
    push_seq(16'd31, 8);
    wait_valid("bp", 20, -1, 0, cyc);
    saved = data_o;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      check_eq("bp_ren", {127'b0, last_ren}, 128'd0);
      check_eq("bp_valid", {127'b0, valid_o}, 128'd1);
      check_eq("bp_data", data_o, saved);
    end
    build_exp(16'd21);
    check_eq("bp_data_value", saved, exp_vec);
    tick(1'b1, 1'b0);
    check_eq("bp_take_ren", {127'b0, last_ren}, 128'd1);
    wait_valid("bp2", 20, -1, 0, cyc);
    build_exp(16'd31);
    check_eq("bp2_latency", cyc, 7);
    check_eq("bp2_data", data_o, exp_vec);
    tick(1'b1, 1'b0);

    // Overlap: yumi on the first valid cycle
    push_seq(16'd41, 16);
    wait_valid("ov", 20, -1, 0, cyc);
    build_exp(16'd41);
    check_eq("ov_data1", data_o, exp_vec);
    tick(1'b1, 1'b0);
    check_eq("ov_take_ren", {127'b0, last_ren}, 128'd1);
    wait_valid("ov2", 20, -1, 0, cyc);
    build_exp(16'd49);
    check_eq("ov2_latency", cyc + 1, 8);
    check_eq("ov2_data", data_o, exp_vec);
    tick(1'b1, 1'b0);
    check_eq("ov_fifo_drained", fifo_q.size(), 0);

    // Reset after 3 words
    push_seq(16'h0100, 8);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    empty_i = 1'b0;
    reset_i = 1'b1;
    #1;
    check_eq("mrst_ren", {127'b0, ren_o}, 128'd0);
    check_eq("mrst_valid", {127'b0, valid_o}, 128'd0);
    check_eq("mrst_data", data_o, 128'd0);
    @(negedge clk);
    reset_i = 1'b0;
    fifo_q.delete();
    push_seq(16'h0A00, 8);
    pops = 0;
    wait_valid("mrst", 20, -1, 0, cyc);
    build_exp(16'h0A00);
    check_eq("mrst_latency", cyc, 8);
    check_eq("mrst_data_after", data_o, exp_vec);
    tick(1'b1, 1'b0);

    // Signed bit patterns pass through untouched
    fifo_q.push_back(16'h8000);
    fifo_q.push_back(16'hFFFF);
    fifo_q.push_back(16'h7FFF);
    fifo_q.push_back(16'h0001);
    fifo_q.push_back(16'hFFFE);
    fifo_q.push_back(16'h8001);
    fifo_q.push_back(16'h0000);
    fifo_q.push_back(16'h5555);
    wait_valid("sgn", 20, -1, 0, cyc);
    exp_vec = {16'h5555, 16'h0000, 16'h8001, 16'hFFFE, 16'h0001, 16'h7FFF, 16'hFFFF, 16'h8000};
    check_eq("sgn_e0", data_o[0], 16'h8000);
    check_eq("sgn_e1", data_o[1], 16'hFFFF);
    check_eq("sgn_e2", data_o[2], 16'h7FFF);
    check_eq("sgn_data", data_o, exp_vec);
    tick(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
